bmi_class_scheduler: RTL and testbench

- Shares one instance of the existing BMI `comparator` between N_REQ requesting stations.
- Round-robin arbitration picks one requester. Its 8-bit BMI value is latched and classified, and the result is returned with a one-cycle ack.
- Keeps per-class saturating statistics counters.
- Sits between the station front-ends and the classification datapath.

---
 rtl/bmi_class_scheduler_pkg.sv | 19 +
 rtl/bmi_class_scheduler_rr_pick.sv | 31 +++
 rtl/comparator.sv | 16 +
 rtl/bmi_class_scheduler.sv | 146 ++++++++++++++
 tb/tb_bmi_class_scheduler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bmi_class_scheduler_pkg.sv
// Shared types and constants for the BMI class scheduler.
// State encoding, class bit positions and the BMI class thresholds.
package bmi_class_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CLS_OVER  = 2;
  localparam int CLS_NORM  = 1;
  localparam int CLS_UNDER = 0;

  // Classification itself lives in comparator; these mirror its boundaries.
  localparam logic [7:0] BMI_UNDER_MAX = 8'd18;
  localparam logic [7:0] BMI_OVER_MIN  = 8'd25;

endpackage

// File: rtl/bmi_class_scheduler_rr_pick.sv
// Round-robin selector: first set request bit at or above ptr, wrapping.
// Combinational, zero latency; any=0 when no request is pending.
module bmi_class_scheduler_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/comparator.sv
// BMI category comparator: splits an 8-bit BMI value into under/normal/over.
// Purely combinational, zero latency, no flow control.
module comparator (
  input  logic [7:0] category,
  output logic       overweight,
  output logic       normal,
  output logic       underweight
);

  always_comb begin
    underweight = (category <= 8'd18);
    overweight  = (category >= 8'd25);
    normal      = !underweight && !overweight;
  end

endmodule

// File: rtl/bmi_class_scheduler.sv
// Shares one BMI comparator among N_REQ stations; round-robin grant, 3-cycle transaction.
// req sampled at edge k -> one-cycle ack between edges k+1 and k+2; stations hold req until acked.
module bmi_class_scheduler
  import bmi_class_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] bmi_in,
  input  logic               clear_stats,
  output logic [N_REQ-1:0]   ack,
  output logic [2:0]         class_out,
  output logic               busy,
  output logic [CNT_W-1:0]   cnt_over,
  output logic [CNT_W-1:0]   cnt_norm,
  output logic [CNT_W-1:0]   cnt_under
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [7:0]         op_q, op_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [2:0]         class_q, class_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_over_q, cnt_over_d;
  logic [CNT_W-1:0]   cnt_norm_q, cnt_norm_d;
  logic [CNT_W-1:0]   cnt_under_q, cnt_under_d;

  logic [PTR_W-1:0]   winner;
  logic               any_req;
  logic               cmp_over, cmp_norm, cmp_under;

  bmi_class_scheduler_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  comparator u_comparator (
    .category    (op_q),
    .overweight  (cmp_over),
    .normal      (cmp_norm),
    .underweight (cmp_under)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    ack_d       = ack_q;
    class_d     = class_q;
    busy_d      = busy_q;
    cnt_over_d  = cnt_over_q;
    cnt_norm_d  = cnt_norm_q;
    cnt_under_d = cnt_under_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          op_d    = bmi_in[8*int'(winner) +: 8];
          owner_d = winner;
          busy_d  = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        class_d         = {cmp_over, cmp_norm, cmp_under};
        ack_d           = '0;
        ack_d[owner_q]  = 1'b1;
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        ack_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = ST_IDLE;
        // Counters saturate rather than wrap so a long run never reads as a small count.
        if (class_q[CLS_OVER] && (cnt_over_q != '1)) begin
          cnt_over_d = cnt_over_q + 1'b1;
        end
        if (class_q[CLS_NORM] && (cnt_norm_q != '1)) begin
          cnt_norm_d = cnt_norm_q + 1'b1;
        end
        if (class_q[CLS_UNDER] && (cnt_under_q != '1)) begin
          cnt_under_d = cnt_under_q + 1'b1;
        end
      end
      default: begin
        ack_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (clear_stats) begin
      cnt_over_d  = '0;
      cnt_norm_d  = '0;
      cnt_under_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      op_q        <= '0;
      ack_q       <= '0;
      class_q     <= '0;
      busy_q      <= 1'b0;
      cnt_over_q  <= '0;
      cnt_norm_q  <= '0;
      cnt_under_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      ack_q       <= ack_d;
      class_q     <= class_d;
      busy_q      <= busy_d;
      cnt_over_q  <= cnt_over_d;
      cnt_norm_q  <= cnt_norm_d;
      cnt_under_q <= cnt_under_d;
    end
  end

  assign ack       = ack_q;
  assign class_out = class_q;
  assign busy      = busy_q;
  assign cnt_over  = cnt_over_q;
  assign cnt_norm  = cnt_norm_q;
  assign cnt_under = cnt_under_q;

endmodule

// File: tb/tb_bmi_class_scheduler.sv
// Scoreboard bench for bmi_class_scheduler: expected grants queued at issue, checked on ack.
module tb_bmi_class_scheduler;
  import bmi_class_scheduler_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] bmi = '0;
  logic           clear_stats = 1'b0;
  logic [N-1:0]   ack;
  logic [2:0]     class_out;
  logic           busy;
  logic [W-1:0]   cnt_over, cnt_norm, cnt_under;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] cls;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  bmi_class_scheduler #(.N_REQ(N), .CNT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .bmi_in      (bmi),
    .clear_stats (clear_stats),
    .ack         (ack),
    .class_out   (class_out),
    .busy        (busy),
    .cnt_over    (cnt_over),
    .cnt_norm    (cnt_norm),
    .cnt_under   (cnt_under)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] cls_of(input logic [7:0] v);
    if (v <= BMI_UNDER_MAX) return 3'b001;
    if (v >= BMI_OVER_MIN)  return 3'b100;
    return 3'b010;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic issue(input int st, input logic [7:0] v);
    exp_t e;
    req[st]         = 1'b1;
    bmi[8*st +: 8]  = v;
    e.st            = 3'(st);
    e.cls           = cls_of(v);
    sb.push_back(e);
  endtask

  task automatic push_exp(input int st, input logic [7:0] v);
    exp_t e;
    e.st  = 3'(st);
    e.cls = cls_of(v);
    sb.push_back(e);
  endtask

  task automatic chk_cnt(input string tag, input int o, input int nm, input int u);
    chk({tag, "_over"}, 32'(cnt_over), o);
    chk({tag, "_norm"}, 32'(cnt_norm), nm);
    chk({tag, "_under"}, 32'(cnt_under), u);
  endtask

  // Acts as the requesters: drops req on ack, optionally re-raises it in the next idle cycle.
  task automatic run_until(input int n, input logic [N-1:0] sticky, input bit clr_last);
    int         got = 0;
    int         budget = n * 4 + 20;
    int         last_cyc = -1;
    logic [N-1:0] pend = '0;
    exp_t       e;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      clear_stats = 1'b0;
      if (ack != '0) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(ack), 0);
        end else begin
          e = sb.pop_front();
          chk("ack", 32'(ack), 32'(1) << e.st);
          chk("class", 32'(class_out), 32'(e.cls));
        end
        if (last_cyc >= 0) chk("gap", 32'(cyc - last_cyc), 3);
        last_cyc = cyc;
        req  = req & ~ack;
        pend = ack & sticky;
        got++;
        if (clr_last && got == n) clear_stats = 1'b1;
      end else begin
        req  = req | pend;
        pend = '0;
      end
    end
    if (got < n) chk("timeout", 32'(got), 32'(n));
    @(negedge clk);
    clear_stats = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sweep [5];
    logic       saw_ack;
    sweep[0] = 8'd0;  sweep[1] = 8'd19; sweep[2] = 8'd24;
    sweep[3] = 8'd25; sweep[4] = 8'd255;

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_class", 32'(class_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk_cnt("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request: latency and busy window.
    req[0] = 1'b1;
    bmi[7:0] = 8'd18;
    @(posedge clk); @(negedge clk);
    chk("t1_ack_k", 32'(ack), 0);
    chk("t1_busy_k", 32'(busy), 1);
    @(posedge clk); @(negedge clk);
    chk("t1_ack_k1", 32'(ack), 1);
    chk("t1_busy_k1", 32'(busy), 1);
    chk("t1_class", 32'(class_out), 3'b001);
    req[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t1_ack_k2", 32'(ack), 0);
    chk("t1_busy_k2", 32'(busy), 0);
    chk("t1_class_hold", 32'(class_out), 3'b001);
    chk("t1_cnt_under", 32'(cnt_under), 1);

    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk_cnt("clr_idle", 0, 0, 0);

    foreach (sweep[i]) begin
      issue(1, sweep[i]);
      run_until(1, '0, 1'b0);
    end
    chk_cnt("sweep", 2, 2, 1);

    // Serve station 3 so the pointer wraps back to 0 before the burst.
    issue(3, 8'd22);
    run_until(1, '0, 1'b0);
    issue(0, 8'd10); issue(1, 8'd20); issue(2, 8'd30); issue(3, 8'd18);
    run_until(4, '0, 1'b0);
    chk_cnt("burst", 3, 4, 3);

    bmi[7:0]   = 8'd12;
    bmi[23:16] = 8'd40;
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 8'd12);
      push_exp(2, 8'd40);
    end
    req = 4'b0101;
    run_until(6, 4'b0101, 1'b0);
    chk_cnt("alt", 6, 4, 6);

    bmi[7:0] = 8'd200;
    for (int i = 0; i < 259; i++) push_exp(0, 8'd200);
    req[0] = 1'b1;
    run_until(259, 4'b0001, 1'b0);
    chk_cnt("sat", 255, 4, 6);
    issue(0, 8'd200);
    run_until(1, '0, 1'b1);
    chk_cnt("clr_cmpl", 0, 0, 0);
    chk("sb_drained", 32'(sb.size()), 0);

    // Reset while the transaction is in EVAL.
    req[1] = 1'b1;
    bmi[15:8] = 8'd20;
    @(posedge clk); @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_class", 32'(class_out), 0);
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    saw_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0) saw_ack = 1'b1;
    end
    chk("mid_no_ack", 32'(saw_ack), 0);
    issue(2, 8'd25);
    run_until(1, '0, 1'b0);
    chk_cnt("post_rst", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
